// File: rtl/noc_output_allocator.sv
// Output-port switch allocator: round-robin arbitration, wormhole locking, downstream credits.
// Define NOC_ALLOC_STALL_CNT_EN to add the credit-stall counter output stall_cnt.
module noc_output_allocator #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter int IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   disable_in,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic [IDX_WIDTH-1:0]    grant_idx,
    output logic                    send_out,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    locked,
    output logic [IDX_WIDTH-1:0]    lock_idx,
    output logic                    credit_err
`ifdef NOC_ALLOC_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [CREDIT_WIDTH-1:0] MAX_CRED = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    state_t                  state, state_nxt;
    logic [IDX_WIDTH-1:0]    owner, owner_nxt;
    logic [IDX_WIDTH-1:0]    rr_ptr, rr_nxt;
    logic [IDX_WIDTH-1:0]    win;
    logic                    found;
    logic [NUM_INPUTS-1:0]   eligible;

    // Wrap at NUM_INPUTS-1 so non-power-of-two port counts never visit unused indices.
    function automatic logic [IDX_WIDTH-1:0] inc_wrap(input logic [IDX_WIDTH-1:0] i);
        return (int'(i) == NUM_INPUTS - 1) ? '0 : i + 1'b1;
    endfunction

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        int                   j;
        logic [IDX_WIDTH-1:0] cand;
        j         = 0;
        cand      = '0;
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        grant     = '0;
        win       = '0;
        found     = 1'b0;
        eligible  = req & ~disable_in;
        if (!rst_noc_sync && credits != '0) begin
            if (state == IDLE) begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    j = int'(rr_ptr) + k;
                    if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
                    cand = IDX_WIDTH'(j);
                    if (!found && eligible[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
            end else if (req[owner]) begin
                // Mid-packet: only the owner may send; disable_in no longer applies.
                found = 1'b1;
                win   = owner;
            end
        end
        if (found) begin
            grant[win] = 1'b1;
            if (req_is_tail[win]) begin
                state_nxt = IDLE;
                owner_nxt = '0;
                rr_nxt    = inc_wrap(win);
            end else begin
                state_nxt = LOCKED;
                owner_nxt = win;
            end
        end
    end

    assign grant_idx = win;
    assign send_out  = found;
    assign locked    = (state == LOCKED);
    assign lock_idx  = locked ? owner : '0;

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            owner      <= '0;
            rr_ptr     <= '0;
            credits    <= MAX_CRED;
            credit_err <= 1'b0;
        end else begin
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
            if (credit_in && !send_out && credits == MAX_CRED)
                credit_err <= 1'b1;
            else
                credits <= credits - CREDIT_WIDTH'(send_out) + CREDIT_WIDTH'(credit_in);
        end
    end

`ifdef NOC_ALLOC_STALL_CNT_EN
    logic stall;
    assign stall = (credits == '0) && ((state == IDLE) ? (|eligible) : req[owner]);

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_noc_output_allocator.sv
// Randomized + directed bench for noc_output_allocator against a transaction-level reference model.
module tb_noc_output_allocator;
    localparam int N = 5;
    localparam int D = 2;

    logic       clk_noc = 1'b0;
    logic       rst_noc_sync;
    logic [4:0] req, req_is_tail, disable_in;
    logic       credit_in;
    logic [4:0] grant;
    logic [2:0] grant_idx, lock_idx;
    logic       send_out, locked, credit_err;
    logic [1:0] credits;
`ifdef NOC_ALLOC_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    noc_output_allocator #(.NUM_INPUTS(N), .FLIT_BUFFER_DEPTH(D)) dut (
        .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync), .req(req), .req_is_tail(req_is_tail),
        .disable_in(disable_in), .credit_in(credit_in), .grant(grant), .grant_idx(grant_idx),
        .send_out(send_out), .credits(credits), .locked(locked), .lock_idx(lock_idx),
        .credit_err(credit_err)
`ifdef NOC_ALLOC_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk_noc = ~clk_noc;

    int total = 0, bad = 0;

    // Reference model: packet owner, next-priority port, free slots, sticky error.
    bit m_locked;
    int m_owner, m_rr, m_cred, exp_win;
    bit m_err;

    function automatic int exp_idx();
        return (exp_win < 0) ? 0 : exp_win;
    endfunction

    function automatic logic [4:0] exp_grant();
        logic [4:0] g;
        g = '0;
        if (exp_win >= 0) g[exp_win] = 1'b1;
        return g;
    endfunction

    task automatic apply(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                         input logic [4:0] ds, input logic ci);
        rst_noc_sync = r; req = rq; req_is_tail = tl; disable_in = ds; credit_in = ci;
        exp_win = -1;
        if (!r && m_cred > 0) begin
            if (m_locked) begin
                if (rq[m_owner]) exp_win = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (exp_win < 0 && rq[(m_rr + k) % N] && !ds[(m_rr + k) % N])
                        exp_win = (m_rr + k) % N;
                end
            end
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk_noc);
        if (rst_noc_sync) begin
            m_locked = 0; m_owner = 0; m_rr = 0; m_cred = D; m_err = 0;
        end else begin
            if (exp_win >= 0) begin
                if (req_is_tail[exp_win]) begin m_locked = 0; m_owner = 0; m_rr = (exp_win + 1) % N; end
                else begin m_locked = 1; m_owner = exp_win; end
            end
            if (credit_in && exp_win < 0 && m_cred == D) m_err = 1;
            else m_cred = m_cred - ((exp_win >= 0) ? 1 : 0) + (credit_in ? 1 : 0);
        end
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 5'b0, 5'b0, 5'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        apply(1'b1, 5'b11111, 5'b0, 5'b0, 1'b1);
        total++; if (grant !== 5'b0 || send_out !== 1'b0 || grant_idx !== 3'd0) begin
            bad++; $display("FAIL reset_outputs grant=%b send=%b idx=%0d want 0", grant, send_out, grant_idx); end
        tick();
        apply(1'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        total++; if (credits !== 2'd2 || locked !== 1'b0 || lock_idx !== 3'd0 || credit_err !== 1'b0) begin
            bad++; $display("FAIL reset_state cred=%0d lk=%b li=%0d err=%b want 2 0 0 0", credits, locked, lock_idx, credit_err); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply(1'b0, 5'b00110, 5'b00110, 5'b0, c != 0);
            total++; if (grant_idx !== ((c % 2 == 0) ? 3'd1 : 3'd2) || send_out !== 1'b1) begin
                bad++; $display("FAIL rr_seq c=%0d idx=%0d send=%b want %0d 1", c, grant_idx, send_out, (c % 2 == 0) ? 1 : 2); end
            total++; if (locked !== 1'b0 || credits < 2'd1) begin
                bad++; $display("FAIL rr_state c=%0d lk=%b cred=%0d want 0 >=1", c, locked, credits); end
            tick();
        end
    endtask

    task automatic test_wormhole();
        int want [4] = '{3, 3, 3, 1};
        bit wlk [4]  = '{0, 1, 1, 0};
        do_reset();
        apply(1'b0, 5'b00010, 5'b00010, 5'b0, 1'b1);
        tick();
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, 5'b01010, (c == 2) ? 5'b01010 : 5'b00010, 5'b0, 1'b1);
            total++; if (grant_idx !== 3'(want[c]) || grant !== exp_grant()) begin
                bad++; $display("FAIL worm_grant c=%0d idx=%0d g=%b want %0d %b", c, grant_idx, grant, want[c], exp_grant()); end
            total++; if (locked !== wlk[c] || lock_idx !== (wlk[c] ? 3'd3 : 3'd0)) begin
                bad++; $display("FAIL worm_lock c=%0d lk=%b li=%0d want %b %0d", c, locked, lock_idx, wlk[c], wlk[c] ? 3 : 0); end
            tick();
        end
    endtask

    task automatic test_credits();
        bit wsend [8] = '{1, 1, 0, 0, 1, 0, 1, 1};
        bit cin [8]   = '{0, 0, 0, 1, 0, 1, 1, 1};
        int wcred [8] = '{2, 1, 0, 0, 1, 0, 1, 1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply(1'b0, 5'b00001, (c == 7) ? 5'b00001 : 5'b0, 5'b0, cin[c]);
            total++; if (send_out !== wsend[c] || credits !== 2'(wcred[c])) begin
                bad++; $display("FAIL credit c=%0d send=%b cred=%0d want %b %0d", c, send_out, credits, wsend[c], wcred[c]); end
            tick();
        end
        apply(1'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        total++; if (credits !== 2'd1 || locked !== 1'b0) begin
            bad++; $display("FAIL credit_end cred=%0d lk=%b want 1 0", credits, locked); end
    endtask

    task automatic test_overflow();
        do_reset();
        apply(1'b0, 5'b0, 5'b0, 5'b0, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, (c == 1) ? 5'b00001 : 5'b0, 5'b11111, 5'b0, 1'b0);
            total++; if (credit_err !== 1'b1 || credits !== ((c == 2) ? 2'd1 : 2'd2)) begin
                bad++; $display("FAIL overflow c=%0d err=%b cred=%0d want 1 %0d", c, credit_err, credits, (c == 2) ? 1 : 2); end
            tick();
        end
        do_reset();
        apply(1'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        total++; if (credit_err !== 1'b0) begin
            bad++; $display("FAIL overflow_clear err=%b want 0", credit_err); end
    endtask

    task automatic test_disable();
        do_reset();
        apply(1'b0, 5'b00100, 5'b0, 5'b00100, 1'b0);
        total++; if (grant !== 5'b0 || send_out !== 1'b0) begin
            bad++; $display("FAIL dis_block g=%b send=%b want 0 0", grant, send_out); end
        tick();
        apply(1'b0, 5'b10100, 5'b10000, 5'b00100, 1'b1);
        total++; if (grant_idx !== 3'd4 || grant !== 5'b10000) begin
            bad++; $display("FAIL dis_other idx=%0d g=%b want 4", grant_idx, grant); end
        tick();
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, 5'b00100, (c == 2) ? 5'b00100 : 5'b0, (c == 0) ? 5'b0 : 5'b00100, 1'b1);
            total++; if (send_out !== (c < 3) || grant_idx !== ((c < 3) ? 3'd2 : 3'd0)) begin
                bad++; $display("FAIL dis_mid c=%0d send=%b idx=%0d want %b %0d", c, send_out, grant_idx, c < 3, (c < 3) ? 2 : 0); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(1'b0, 5'b00100, 5'b0, 5'b0, 1'b0);
        tick();
        total++; if (locked !== 1'b1 || lock_idx !== 3'd2) begin
            bad++; $display("FAIL rmid_lock lk=%b li=%0d want 1 2", locked, lock_idx); end
        do_reset();
        apply(1'b0, 5'b00101, 5'b0, 5'b0, 1'b0);
        total++; if (locked !== 1'b0 || credits !== 2'd2 || grant_idx !== 3'd0 || send_out !== 1'b1) begin
            bad++; $display("FAIL rmid_after lk=%b cred=%0d idx=%0d send=%b want 0 2 0 1", locked, credits, grant_idx, send_out); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            apply($urandom_range(0, 149) == 0, 5'($urandom), 5'($urandom & $urandom),
                  5'($urandom & $urandom & $urandom), 1'($urandom));
            total++; if (grant !== exp_grant() || grant_idx !== 3'(exp_idx()) || send_out !== (exp_win >= 0)) begin
                bad++; $display("FAIL rand_grant c=%0d g=%b idx=%0d send=%b want %b %0d %b", c, grant, grant_idx, send_out, exp_grant(), exp_idx(), exp_win >= 0); end
            total++; if (credits !== 2'(m_cred) || locked !== m_locked || lock_idx !== 3'(m_locked ? m_owner : 0) || credit_err !== m_err) begin
                bad++; $display("FAIL rand_state c=%0d cred=%0d lk=%b li=%0d err=%b want %0d %b %0d %b", c, credits, locked, lock_idx, credit_err, m_cred, m_locked, m_locked ? m_owner : 0, m_err); end
            tick();
        end
    endtask

    initial begin
        m_locked = 0; m_owner = 0; m_rr = 0; m_cred = D; m_err = 0; exp_win = -1;
        rst_noc_sync = 1'b1; req = '0; req_is_tail = '0; disable_in = '0; credit_in = 1'b0;
        @(posedge clk_noc); #1;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credits();
        test_overflow();
        test_disable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
